// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package dmem_pkg;

  // Access size as carried on the request bus
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  // Load/store sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  // Byte-lane pattern of an access that starts at lane 0
  function automatic logic [3:0] size_mask(input size_e size);
    case (size)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Number of bytes touched by an access (0 for the illegal size)
  function automatic logic [2:0] size_bytes(input size_e size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Two-word lane pattern: low nibble is the first word, high nibble the next
  function automatic logic [7:0] lane_mask(input size_e size, input logic [1:0] offset);
    return {4'b0000, size_mask(size)} << offset;
  endfunction

  // True when the access spills past the end of its first word
  function automatic logic crosses_word(input size_e size, input logic [1:0] offset);
    return ({1'b0, offset} + size_bytes(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response and memory-port signals of the load/store unit.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_a;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;

  // The load/store unit itself
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, dmem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output dmem_we, dmem_be, dmem_a, dmem_wd
  );

  // The pipeline and memory around it
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, dmem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  dmem_we, dmem_be, dmem_a, dmem_wd
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte-enable pattern, write-data placement for
// both halves of a (possibly split) access, and load extract/extend.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_data,
  input  logic [31:0] hi_data,
  output logic [7:0]  mask,
  output logic [31:0] wd_lo,
  output logic [31:0] wd_hi,
  output logic [31:0] load_data
);

  logic [5:0]  shift_lo;
  logic [5:0]  shift_hi;
  logic [31:0] raw;
  logic        sign_bit;

  // Lane placement of store data and extraction of load data
  always_comb begin
    mask     = lane_mask(size, offset);
    shift_lo = {1'b0, offset, 3'b000};
    // offset 0 gives a 32-bit shift, which empties the second-word data
    shift_hi = 6'd32 - shift_lo;
    wd_lo    = wdata << shift_lo;
    wd_hi    = wdata >> shift_hi;
    raw      = 32'({hi_data, lo_data} >> shift_lo);
    sign_bit = 1'b0;
    load_data = 32'h0;
    case (size)
      SZ_BYTE: begin
        sign_bit  = is_signed & raw[7];
        load_data = {{24{sign_bit}}, raw[7:0]};
      end
      SZ_HALF: begin
        sign_bit  = is_signed & raw[15];
        load_data = {{16{sign_bit}}, raw[15:0]};
      end
      SZ_WORD: load_data = raw;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between the core pipeline and the byte-enabled data
// memory. Word-crossing accesses are split into two aligned accesses unless
// ALLOW_UNALIGNED is cleared, in which case they are answered with an error.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter bit ALLOW_UNALIGNED = 1'b1
) (
  input  logic clk,
  input  logic reset,
  dmem_lsu_if.slave bus
);

  lsu_state_t  state_reg;
  lsu_state_t  state_next;

  logic        we_reg;
  logic        signed_reg;
  logic        err_reg;
  size_e       size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] lo_buf_reg;
  logic [31:0] hi_buf_reg;

  logic        accept;
  logic        req_err;
  logic [31:0] word_addr;
  logic [7:0]  mask;
  logic [31:0] wd_lo;
  logic [31:0] wd_hi;
  logic [31:0] load_data;
  logic        in_resp;

  dmem_lane_align u_align (
    .size      (size_reg),
    .offset    (addr_reg[1:0]),
    .is_signed (signed_reg),
    .wdata     (wdata_reg),
    .lo_data   (lo_buf_reg),
    .hi_data   (hi_buf_reg),
    .mask      (mask),
    .wd_lo     (wd_lo),
    .wd_hi     (wd_hi),
    .load_data (load_data)
  );

  assign accept    = (state_reg == ST_IDLE) && bus.req_valid;
  assign word_addr = {addr_reg[31:2], 2'b00};
  assign in_resp   = (state_reg == ST_RESP) && !reset;

  // Decide up front whether a new request is answered without touching memory
  always_comb begin
    req_err = (bus.req_size == SZ_ILL);
    if (!ALLOW_UNALIGNED && crosses_word(size_e'(bus.req_size), bus.req_addr[1:0])) begin
      req_err = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and memory-port drive; everything is quiet while reset is high
  always_comb begin
    state_next    = state_reg;
    bus.req_ready = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.dmem_be   = 4'b0000;
    bus.dmem_a    = 32'h0;
    bus.dmem_wd   = 32'h0;
    case (state_reg)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_next = req_err ? ST_RESP : ST_ACC0;
        end
      end
      ST_ACC0: begin
        bus.dmem_a  = word_addr;
        bus.dmem_be = mask[3:0];
        bus.dmem_wd = wd_lo;
        bus.dmem_we = we_reg;
        state_next  = (mask[7:4] != 4'b0000) ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        bus.dmem_a  = word_addr + 32'd4;
        bus.dmem_be = mask[7:4];
        bus.dmem_wd = wd_hi;
        bus.dmem_we = we_reg;
        state_next  = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (reset) begin
      bus.dmem_we = 1'b0;
      bus.dmem_be = 4'b0000;
      bus.dmem_a  = 32'h0;
      bus.dmem_wd = 32'h0;
    end
  end

  // Response is driven straight from the held request and read buffers
  assign bus.resp_valid = in_resp;
  assign bus.resp_err   = in_resp && err_reg;
  assign bus.resp_rdata = (in_resp && !err_reg && !we_reg) ? load_data : 32'h0;

  // Latch the request fields on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg     <= 1'b0;
      signed_reg <= 1'b0;
      err_reg    <= 1'b0;
      size_reg   <= SZ_BYTE;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
    end else if (accept) begin
      we_reg     <= bus.req_we;
      signed_reg <= bus.req_signed;
      err_reg    <= req_err;
      size_reg   <= size_e'(bus.req_size);
      addr_reg   <= bus.req_addr;
      wdata_reg  <= bus.req_wdata;
    end
  end

  // Collect read data from each memory word of the access
  always_ff @(posedge clk) begin
    if (reset) begin
      lo_buf_reg <= 32'h0;
      hi_buf_reg <= 32'h0;
    end else if (accept) begin
      lo_buf_reg <= 32'h0;
      hi_buf_reg <= 32'h0;
    end else if (state_reg == ST_ACC0) begin
      lo_buf_reg <= bus.dmem_rd;
    end else if (state_reg == ST_ACC1) begin
      hi_buf_reg <= bus.dmem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: two instances (unaligned allowed / not allowed) share a
// byte-addressed memory model and are checked against a byte-level reference.
module tb_dmem_lsu;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] wd;
  } acc_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Stimulus, routed to one instance at a time by sel
  logic        sel;
  logic        req_valid, req_we, req_signed, resp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, mem_rd;

  dmem_lsu_if bus0();
  dmem_lsu_if bus1();

  dmem_lsu #(.ALLOW_UNALIGNED(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_lsu #(.ALLOW_UNALIGNED(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  assign bus0.req_valid  = req_valid & ~sel;
  assign bus1.req_valid  = req_valid & sel;
  assign bus0.resp_ready = resp_ready & ~sel;
  assign bus1.resp_ready = resp_ready & sel;
  assign bus0.req_we = req_we;         assign bus1.req_we = req_we;
  assign bus0.req_size = req_size;     assign bus1.req_size = req_size;
  assign bus0.req_signed = req_signed; assign bus1.req_signed = req_signed;
  assign bus0.req_addr = req_addr;     assign bus1.req_addr = req_addr;
  assign bus0.req_wdata = req_wdata;   assign bus1.req_wdata = req_wdata;
  assign bus0.dmem_rd = mem_rd;        assign bus1.dmem_rd = mem_rd;

  wire        o_req_ready  = sel ? bus1.req_ready  : bus0.req_ready;
  wire        o_resp_valid = sel ? bus1.resp_valid : bus0.resp_valid;
  wire [31:0] o_resp_rdata = sel ? bus1.resp_rdata : bus0.resp_rdata;
  wire        o_resp_err   = sel ? bus1.resp_err   : bus0.resp_err;
  wire        o_dmem_we    = sel ? bus1.dmem_we    : bus0.dmem_we;
  wire [3:0]  o_dmem_be    = sel ? bus1.dmem_be    : bus0.dmem_be;
  wire [31:0] o_dmem_a     = sel ? bus1.dmem_a     : bus0.dmem_a;
  wire [31:0] o_dmem_wd    = sel ? bus1.dmem_wd    : bus0.dmem_wd;

  // Byte-addressed memory; unwritten bytes hold an address-derived pattern
  logic [7:0] mem_b [logic [31:0]];
  acc_t acc_q[$];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Memory read data follows the address shortly after each edge
  initial begin
    mem_rd = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      mem_rd = mem_word(o_dmem_a);
    end
  end

  // Record every memory access mid-cycle and commit enabled write bytes
  always @(negedge clk) begin
    if (o_dmem_we || o_dmem_be != 4'b0000) begin
      acc_q.push_back('{we: o_dmem_we, be: o_dmem_be, a: o_dmem_a, wd: o_dmem_wd});
    end
    if (o_dmem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (o_dmem_be[l]) mem_b[o_dmem_a + 32'(l)] = o_dmem_wd[8*l +: 8];
      end
    end
  end

  // Reference: walk the bytes of the access, group them by word
  function automatic void model(
    input  logic we, input logic [1:0] size, input logic sgn,
    input  logic [31:0] addr, input logic [31:0] wdata, input logic allow,
    output logic [31:0] rdata, output logic err, output int lat, output int n,
    output logic [1:0][31:0] ea, output logic [1:0][3:0] ebe, output logic [1:0][31:0] ewd);
    int nb;
    int wi;
    logic [31:0] w0, last, ba, val;
    logic split;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    ea = '0; ebe = '0; ewd = '0; rdata = 32'h0; val = 32'h0;
    w0 = addr & ~32'h3;
    ea[0] = w0;
    ea[1] = w0 + 32'd4;
    if (nb == 0) begin err = 1'b1; lat = 1; n = 0; return; end
    last  = addr + 32'(nb - 1);
    split = ((last & ~32'h3) != w0);
    if (split && !allow) begin err = 1'b1; lat = 1; n = 0; return; end
    err = 1'b0;
    n   = split ? 2 : 1;
    lat = split ? 3 : 2;
    for (int i = 0; i < nb; i++) begin
      ba = addr + 32'(i);
      wi = ((ba & ~32'h3) == w0) ? 0 : 1;
      ebe[wi][ba[1:0]] = 1'b1;
      ewd[wi][8*ba[1:0] +: 8] = wdata[8*i +: 8];
      val[8*i +: 8] = mem_byte(ba);
    end
    if (sgn && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
    rdata = we ? 32'h0 : val;
  endfunction

  // Drive one request, wait (bounded) for the response, then take it
  task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
    acc_q.delete();
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!o_resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = o_resp_rdata;
    err   = o_resp_err;
    $display("txn dut%0d we=%0d size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d acc=%0d",
             sel, we, size, sgn, addr, wdata, rdata, err, lat, acc_q.size());
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", o_req_ready); end
    checks++; if (o_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b want=0", o_resp_valid); end
    checks++; if (o_resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b want=0", o_resp_err); end
    checks++; if (o_resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got=%h want=0", o_resp_rdata); end
    checks++; if ({o_dmem_we, o_dmem_be} !== 5'b0) begin errors++; $display("FAIL reset_dmem_we_be got=%b/%b want=0/0000", o_dmem_we, o_dmem_be); end
    checks++; if (o_dmem_a !== 32'h0) begin errors++; $display("FAIL reset_dmem_a got=%h want=0", o_dmem_a); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_strb();
    logic [31:0] rd; logic er; int lat;
    run_txn(1'b1, 2'd0, 1'b0, 32'h103, 32'hAB, rd, er, lat);
    checks++; if (acc_q.size() !== 1) begin errors++; $display("FAIL strb_count got=%0d want=1", acc_q.size()); end
    if (acc_q.size() > 0) begin
      checks++; if (acc_q[0].a !== 32'h100 || acc_q[0].be !== 4'b1000 || acc_q[0].we !== 1'b1)
        begin errors++; $display("FAIL strb_acc got a=%h be=%b we=%b want a=100 be=1000 we=1", acc_q[0].a, acc_q[0].be, acc_q[0].we); end
      checks++; if (acc_q[0].wd[31:24] !== 8'hAB) begin errors++; $display("FAIL strb_wd got=%h want=AB", acc_q[0].wd[31:24]); end
    end
    checks++; if (lat !== 2 || er !== 1'b0 || rd !== 32'h0)
      begin errors++; $display("FAIL strb_resp got lat=%0d err=%b rdata=%h want 2/0/0", lat, er, rd); end
  endtask

  task automatic test_ldrh_signed();
    logic [31:0] rd; logic er; int lat;
    mem_b[32'h100] = 8'h00; mem_b[32'h101] = 8'h00; mem_b[32'h102] = 8'hFF; mem_b[32'h103] = 8'h80;
    run_txn(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, rd, er, lat);
    checks++; if (acc_q.size() !== 1 || (acc_q.size() > 0 && acc_q[0].be !== 4'b1100))
      begin errors++; $display("FAIL ldrh_be got n=%0d be=%b want n=1 be=1100", acc_q.size(), acc_q.size() > 0 ? acc_q[0].be : 4'b0); end
    checks++; if (rd !== 32'hFFFF_80FF || er !== 1'b0 || lat !== 2)
      begin errors++; $display("FAIL ldrh_resp got rdata=%h err=%b lat=%0d want FFFF80FF/0/2", rd, er, lat); end
  endtask

  task automatic test_ldr_split();
    logic [31:0] rd; logic er; int lat;
    logic [63:0] bytes8;
    bytes8 = 64'h8877_6655_4433_2211;
    for (int i = 0; i < 8; i++) mem_b[32'h200 + 32'(i)] = bytes8[8*i +: 8];
    run_txn(1'b0, 2'd2, 1'b0, 32'h201, 32'h0, rd, er, lat);
    checks++; if (acc_q.size() !== 2) begin errors++; $display("FAIL ldr_split_count got=%0d want=2", acc_q.size()); end
    if (acc_q.size() == 2) begin
      checks++; if (acc_q[0].a !== 32'h200 || acc_q[0].be !== 4'b1110 || acc_q[1].a !== 32'h204 || acc_q[1].be !== 4'b0001)
        begin errors++; $display("FAIL ldr_split_acc got %h/%b %h/%b want 200/1110 204/0001", acc_q[0].a, acc_q[0].be, acc_q[1].a, acc_q[1].be); end
    end
    checks++; if (rd !== 32'h5544_3322 || lat !== 3)
      begin errors++; $display("FAIL ldr_split_resp got rdata=%h lat=%0d want 55443322/3", rd, lat); end
  endtask

  task automatic test_str_wrap();
    logic [31:0] rd; logic er; int lat;
    run_txn(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hDDCC_BBAA, rd, er, lat);
    checks++; if (acc_q.size() !== 2) begin errors++; $display("FAIL str_wrap_count got=%0d want=2", acc_q.size()); end
    if (acc_q.size() == 2) begin
      checks++; if (acc_q[0].a !== 32'hFFFF_FFFC || acc_q[0].be !== 4'b1100 || acc_q[0].wd[31:16] !== 16'hBBAA)
        begin errors++; $display("FAIL str_wrap_acc0 got a=%h be=%b wd=%h want FFFFFFFC/1100/BBAAxxxx", acc_q[0].a, acc_q[0].be, acc_q[0].wd); end
      checks++; if (acc_q[1].a !== 32'h0 || acc_q[1].be !== 4'b0011 || acc_q[1].wd[15:0] !== 16'hDDCC || acc_q[1].we !== 1'b1)
        begin errors++; $display("FAIL str_wrap_acc1 got a=%h be=%b wd=%h we=%b want 0/0011/xxxxDDCC/1", acc_q[1].a, acc_q[1].be, acc_q[1].wd, acc_q[1].we); end
    end
    checks++; if (lat !== 3 || er !== 1'b0) begin errors++; $display("FAIL str_wrap_resp got lat=%0d err=%b want 3/0", lat, er); end
  endtask

  task automatic test_no_unaligned();
    logic [31:0] rd; logic er; int lat;
    sel = 1'b1;
    run_txn(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || acc_q.size() !== 0)
      begin errors++; $display("FAIL noua_ldr6 got err=%b rdata=%h lat=%0d acc=%0d want 1/0/1/0", er, rd, lat, acc_q.size()); end
    run_txn(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0 || acc_q.size() !== 0)
      begin errors++; $display("FAIL noua_size3 got err=%b rdata=%h acc=%0d want 1/0/0", er, rd, acc_q.size()); end
    run_txn(1'b0, 2'd0, 1'b0, 32'h3, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== {24'h0, mem_byte(32'h3)} || lat !== 2)
      begin errors++; $display("FAIL noua_byte3 got err=%b rdata=%h lat=%0d want 0/%h/2", er, rd, lat, {24'h0, mem_byte(32'h3)}); end
    sel = 1'b0;
    run_txn(1'b1, 2'd3, 1'b0, 32'h20, 32'h1234, rd, er, lat);
    checks++; if (er !== 1'b1 || acc_q.size() !== 0 || lat !== 1)
      begin errors++; $display("FAIL ua_size3 got err=%b acc=%0d lat=%0d want 1/0/1", er, acc_q.size(), lat); end
  endtask

  task automatic test_hold();
    logic [31:0] exp_rd; logic exp_er; int exp_lat, n, w;
    logic [1:0][31:0] ea, ewd; logic [1:0][3:0] ebe;
    mem_b[32'h502] = 8'h34; mem_b[32'h503] = 8'h9C;
    model(1'b0, 2'd1, 1'b1, 32'h502, 32'h0, 1'b1, exp_rd, exp_er, exp_lat, n, ea, ebe, ewd);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_signed = 1'b1; req_addr = 32'h502;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w = 0;
    while (!o_resp_valid && w < 20) begin @(posedge clk); #1; w++; end
    for (int c = 0; c < 5; c++) begin
      checks++; if (o_resp_valid !== 1'b1 || o_resp_rdata !== exp_rd || o_resp_err !== 1'b0 || o_req_ready !== 1'b0)
        begin errors++; $display("FAIL hold_c%0d got v=%b rdata=%h err=%b rdy=%b want 1/%h/0/0", c, o_resp_valid, o_resp_rdata, o_resp_err, o_req_ready, exp_rd); end
      @(posedge clk); #1;
    end
    $display("txn hold rdata=%h", exp_rd);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1)
      begin errors++; $display("FAIL hold_release got v=%b rdy=%b want 0/1", o_resp_valid, o_req_ready); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h602; req_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_dmem_we !== 1'b1 || o_dmem_be !== 4'b0011)
      begin errors++; $display("FAIL abort_acc1 got we=%b be=%b want 1/0011", o_dmem_we, o_dmem_be); end
    reset = 1'b1;
    #1;
    checks++; if (o_dmem_we !== 1'b0 || o_dmem_be !== 4'b0000)
      begin errors++; $display("FAIL abort_gate got we=%b be=%b want 0/0000", o_dmem_we, o_dmem_be); end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0)
      begin errors++; $display("FAIL abort_idle got rdy=%b v=%b want 1/0", o_req_ready, o_resp_valid); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_resp_valid !== 1'b0) begin errors++; $display("FAIL abort_noresp got v=%b want 0", o_resp_valid); end
    $display("txn abort done");
    run_txn(1'b0, 2'd0, 1'b0, 32'h604, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b0 || lat !== 2 || rd !== {24'h0, mem_byte(32'h604)})
      begin errors++; $display("FAIL abort_recover got err=%b lat=%0d rdata=%h want 0/2/%h", er, lat, rd, {24'h0, mem_byte(32'h604)}); end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, addr, wdata; logic er, exp_er, we, sgn; logic [1:0] size;
    int lat, exp_lat, n, r;
    logic [1:0][31:0] ea, ewd; logic [1:0][3:0] ebe;
    logic [31:0] lm;
    for (int t = 0; t < 150; t++) begin
      sel   = ($urandom_range(0, 3) == 0);
      we    = 1'($urandom_range(0, 1));
      sgn   = 1'($urandom_range(0, 1));
      r     = $urandom_range(0, 9);
      size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                          : 32'h400 + 32'($urandom_range(0, 63));
      wdata = $urandom;
      model(we, size, sgn, addr, wdata, ~sel, exp_rd, exp_er, exp_lat, n, ea, ebe, ewd);
      run_txn(we, size, sgn, addr, wdata, rd, er, lat);
      checks++; if (rd !== exp_rd || er !== exp_er || lat !== exp_lat)
        begin errors++; $display("FAIL rand%0d_resp got rdata=%h err=%b lat=%0d want %h/%b/%0d", t, rd, er, lat, exp_rd, exp_er, exp_lat); end
      checks++; if (acc_q.size() !== n) begin errors++; $display("FAIL rand%0d_count got=%0d want=%0d", t, acc_q.size(), n); end
      for (int k = 0; k < n && k < acc_q.size(); k++) begin
        lm = lane_bits(ebe[k]);
        checks++;
        if (acc_q[k].a !== ea[k] || acc_q[k].be !== ebe[k] || acc_q[k].we !== we || (we && ((acc_q[k].wd & lm) !== (ewd[k] & lm))))
          begin errors++; $display("FAIL rand%0d_acc%0d got a=%h be=%b we=%b wd=%h want %h/%b/%b/%h", t, k, acc_q[k].a, acc_q[k].be, acc_q[k].we, acc_q[k].wd, ea[k], ebe[k], we, ewd[k]); end
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    test_reset();
    test_strb();
    test_ldrh_signed();
    test_ldr_split();
    test_str_wrap();
    test_no_unaligned();
    test_hold();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound
  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
